// File: rtl/versat_alu_pkg.sv
// Shared widths, function codes and the data-bus source picker for the Versat ALU.
package versat_alu_pkg;
  localparam int DATA_W        = 32;
  localparam int N             = 8;
  localparam int N_W           = 4;
  localparam int ALU_FNS_W     = 4;
  localparam int ALU_CONF_BITS = 2 * N_W + ALU_FNS_W;
  localparam int CLZ_W         = 6;

  typedef enum logic [ALU_FNS_W-1:0] {
    ALU_OR          = 4'd0,
    ALU_AND         = 4'd1,
    ALU_ANDN        = 4'd2,
    ALU_XOR         = 4'd3,
    ALU_SEXT8       = 4'd4,
    ALU_SEXT16      = 4'd5,
    ALU_SHIFTR_ARTH = 4'd6,
    ALU_SHIFTR_LOG  = 4'd7,
    ALU_CMP_UNS     = 4'd8,
    ALU_CMP_SIG     = 4'd9,
    ALU_ADD         = 4'd10,
    ALU_SUB         = 4'd11,
    ALU_CLZ         = 4'd12,
    ALU_MAX         = 4'd13,
    ALU_MIN         = 4'd14,
    ALU_ABS         = 4'd15
  } alu_fn_e;

  // Source s (1..N) sits at the top of the bus for s=1; select 0 or >N yields 0.
  function automatic logic [DATA_W-1:0] pick_src(input logic [N*DATA_W-1:0] bus_v,
                                                 input logic [N_W-1:0] sel);
    pick_src = '0;
    for (int s = 1; s <= N; s++) begin
      if (int'(sel) == s) pick_src = bus_v[N*DATA_W-DATA_W*(s-1)-1 -: DATA_W];
    end
  endfunction
endpackage

// File: rtl/versat_alu_if.sv
// Controller/data-bus bundle of the Versat ALU.
// rw_req qualifies a controller access with no ready: a write (rw_rnw=0) is always
// taken on the edge it is presented and overrides that cycle's function result.
interface versat_alu_if;
  import versat_alu_pkg::*;

  logic                     rw_req;
  logic                     rw_rnw;
  logic [DATA_W-1:0]        rw_data_to_wr;
  logic [N*DATA_W-1:0]      data_bus;
  logic [ALU_CONF_BITS-1:0] configdata;
  logic [DATA_W-1:0]        alu_result;
  logic                     c_out;

  modport master (
    output rw_req, rw_rnw, rw_data_to_wr, data_bus, configdata,
    input  alu_result, c_out
  );

  modport slave (
    input  rw_req, rw_rnw, rw_data_to_wr, data_bus, configdata,
    output alu_result, c_out
  );
endinterface

// File: rtl/versat_alu_clz.sv
// Combinational leading-zero counter; an all-zero input counts as DATA_W.
module versat_alu_clz
  import versat_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  output logic [CLZ_W-1:0]  cnt
);
  always_comb begin
    cnt = CLZ_W'(DATA_W);
    // Ascending scan: the highest set bit is the last to write the count.
    for (int i = 0; i < DATA_W; i++) begin
      if (a[i]) cnt = CLZ_W'(DATA_W - 1 - i);
    end
  end
endmodule

// File: rtl/versat_alu.sv
// Registered 32-bit ALU: two bus operands, 16 functions, carry/compare flag,
// and a controller write path that overrides the result register.
module versat_alu
  import versat_alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  versat_alu_if.slave  bus
);
  logic [N_W-1:0]    sel_a, sel_b;
  alu_fn_e           fns;
  logic [DATA_W-1:0] op_a, op_b;
  logic [CLZ_W-1:0]  clz_cnt;
  logic [DATA_W:0]   sum, diff;
  logic              signs_differ;
  logic [DATA_W-1:0] max_v, min_v;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic              c_out_d, c_out_q;

  always_comb begin
    sel_a = bus.configdata[ALU_CONF_BITS-1 -: N_W];
    sel_b = bus.configdata[ALU_CONF_BITS-N_W-1 -: N_W];
    fns   = alu_fn_e'(bus.configdata[ALU_FNS_W-1:0]);
    op_a  = pick_src(bus.data_bus, sel_a);
    op_b  = pick_src(bus.data_bus, sel_b);
  end

  versat_alu_clz u_clz (
    .a   (op_a),
    .cnt (clz_cnt)
  );

  always_comb begin
    sum  = {1'b0, op_a} + {1'b0, op_b};
    diff = {1'b0, op_b} + {1'b0, ~op_a} + (DATA_W+1)'(1);
    // Mixed signs pick by sign bit; equal signs reduce to unsigned order. Ties go to B.
    signs_differ = op_a[DATA_W-1] ^ op_b[DATA_W-1];
    if (signs_differ) begin
      max_v = op_a[DATA_W-1] ? op_b : op_a;
      min_v = op_a[DATA_W-1] ? op_a : op_b;
    end else begin
      max_v = (op_a > op_b) ? op_a : op_b;
      min_v = (op_a < op_b) ? op_a : op_b;
    end
  end

  always_comb begin
    alu_result_d = '0;
    c_out_d      = 1'b0;
    case (fns)
      ALU_OR:          alu_result_d = op_a | op_b;
      ALU_AND:         alu_result_d = op_a & op_b;
      ALU_ANDN:        alu_result_d = op_a & ~op_b;
      ALU_XOR:         alu_result_d = op_a ^ op_b;
      ALU_SEXT8:       alu_result_d = {{(DATA_W-8){op_a[7]}}, op_a[7:0]};
      ALU_SEXT16:      alu_result_d = {{(DATA_W-16){op_a[15]}}, op_a[15:0]};
      ALU_SHIFTR_ARTH: alu_result_d = {op_a[DATA_W-1], op_a[DATA_W-1:1]};
      ALU_SHIFTR_LOG:  alu_result_d = {1'b0, op_a[DATA_W-1:1]};
      ALU_CMP_UNS: begin
        alu_result_d = diff[DATA_W-1:0];
        c_out_d      = diff[DATA_W];
      end
      ALU_CMP_SIG: begin
        alu_result_d = diff[DATA_W-1:0];
        c_out_d      = ($signed(op_b) >= $signed(op_a));
      end
      ALU_ADD: begin
        alu_result_d = sum[DATA_W-1:0];
        c_out_d      = sum[DATA_W];
      end
      ALU_SUB: begin
        alu_result_d = diff[DATA_W-1:0];
        c_out_d      = diff[DATA_W];
      end
      ALU_CLZ:         alu_result_d = {{(DATA_W-CLZ_W){1'b0}}, clz_cnt};
      ALU_MAX:         alu_result_d = max_v;
      ALU_MIN:         alu_result_d = min_v;
      ALU_ABS:         alu_result_d = op_a[DATA_W-1] ? ('0 - op_a) : op_a;
      default: begin
        alu_result_d = '0;
        c_out_d      = 1'b0;
      end
    endcase
    if (bus.rw_req && !bus.rw_rnw) begin
      alu_result_d = bus.rw_data_to_wr;
      c_out_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q <= '0;
      c_out_q      <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      c_out_q      <= c_out_d;
    end
  end

  assign bus.alu_result = alu_result_q;
  assign bus.c_out      = c_out_q;
endmodule

// File: tb/tb_versat_alu.sv
// Directed bench for versat_alu: reset, controller write, function sweep, edge cases
// and data-bus source mapping, checked with immediate assertions.
module tb_versat_alu;
  import versat_alu_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [DATA_W-1:0] exp_q[$];

  versat_alu_if bus ();

  versat_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [DATA_W-1:0] v);
    bus.data_bus[N*DATA_W-DATA_W*(s-1)-1 -: DATA_W] = v;
  endtask

  task automatic set_cfg(input logic [N_W-1:0] sa, input logic [N_W-1:0] sb,
                         input logic [ALU_FNS_W-1:0] fn);
    bus.configdata = {sa, sb, fn};
  endtask

  // A on source 1, B on source 2, then one clocked evaluation of fn.
  task automatic run_ab(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [ALU_FNS_W-1:0] fn);
    set_src(1, a);
    set_src(2, b);
    set_cfg(4'd1, 4'd2, fn);
    step();
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [DATA_W-1:0] exp_r,
                           input logic exp_c);
    check({tag, "_res"}, bus.alu_result, exp_r);
    check({tag, "_c"}, {{(DATA_W-1){1'b0}}, bus.c_out}, {{(DATA_W-1){1'b0}}, exp_c});
  endtask

  initial begin
    logic [DATA_W-1:0] e;
    logic              sweep_c[16];
    n_tests = 0;
    n_fail  = 0;
    rst               = 1'b0;
    bus.rw_req        = 1'b0;
    bus.rw_rnw        = 1'b1;
    bus.rw_data_to_wr = '0;
    bus.data_bus      = '0;
    bus.configdata    = '0;

    repeat (2) step();
    check_res("reset_init", 32'h0, 1'b0);
    rst = 1'b1;

    // Build a nonzero result with c_out=1, then drop reset between edges.
    run_ab(32'd25, 32'd26, ALU_SUB);
    check_res("pre_reset_sub", 32'd1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_res("async_reset", 32'h0, 1'b0);
    #1;
    rst = 1'b1;

    // Controller write wins over SUB (which would set c_out).
    bus.rw_req        = 1'b1;
    bus.rw_rnw        = 1'b0;
    bus.rw_data_to_wr = 32'd20;
    step();
    check_res("rw_write", 32'd20, 1'b0);

    // Read requests are side-effect free: sweep all 16 functions.
    bus.rw_rnw = 1'b1;
    foreach (sweep_c[i]) sweep_c[i] = 1'b0;
    sweep_c[8]  = 1'b1;
    sweep_c[9]  = 1'b1;
    sweep_c[11] = 1'b1;
    exp_q = {32'd27, 32'd24, 32'd1, 32'd3, 32'd25, 32'd25, 32'd12, 32'd12,
             32'd1, 32'd1, 32'd51, 32'd1, 32'd27, 32'd26, 32'd25, 32'd25};
    for (int i = 0; i < 16; i++) begin
      run_ab(32'd25, 32'd26, 4'(i));
      e = exp_q.pop_front();
      check_res($sformatf("sweep_fn%0d", i), e, sweep_c[i]);
    end
    bus.rw_req = 1'b0;

    // Sign handling on a negative byte pattern.
    run_ab(32'hFFFF_FF80, 32'h0, ALU_SEXT8);
    check_res("sext8", 32'hFFFF_FF80, 1'b0);
    run_ab(32'hFFFF_FF80, 32'h0, ALU_SEXT16);
    check_res("sext16", 32'hFFFF_FF80, 1'b0);
    run_ab(32'hFFFF_FF80, 32'h0, ALU_SHIFTR_ARTH);
    check_res("sra", 32'hFFFF_FFC0, 1'b0);
    run_ab(32'hFFFF_FF80, 32'h0, ALU_SHIFTR_LOG);
    check_res("srl", 32'h7FFF_FFC0, 1'b0);
    run_ab(32'hFFFF_FF80, 32'h0, ALU_ABS);
    check_res("abs_neg", 32'h0000_0080, 1'b0);
    run_ab(32'h0000_1234, 32'h0, ALU_SEXT16);
    check_res("sext16_pos", 32'h0000_1234, 1'b0);

    // Signed vs unsigned ordering with A = -1, B = 3.
    run_ab(32'hFFFF_FFFF, 32'd3, ALU_MAX);
    check_res("max_mixed", 32'd3, 1'b0);
    run_ab(32'hFFFF_FFFF, 32'd3, ALU_MIN);
    check_res("min_mixed", 32'hFFFF_FFFF, 1'b0);
    run_ab(32'hFFFF_FFFF, 32'd3, ALU_CMP_SIG);
    check_res("cmp_sig", 32'd4, 1'b1);
    run_ab(32'hFFFF_FFFF, 32'd3, ALU_CMP_UNS);
    check_res("cmp_uns", 32'd4, 1'b0);
    run_ab(32'hFFFF_FFFE, 32'hFFFF_FFFB, ALU_MAX);
    check_res("max_both_neg", 32'hFFFF_FFFE, 1'b0);
    run_ab(32'd7, 32'd7, ALU_SUB);
    check_res("sub_equal", 32'd0, 1'b1);

    // Boundaries.
    run_ab(32'h0, 32'h0, ALU_CLZ);
    check_res("clz_zero", 32'd32, 1'b0);
    run_ab(32'h1, 32'h0, ALU_CLZ);
    check_res("clz_one", 32'd31, 1'b0);
    run_ab(32'h8000_0000, 32'h0, ALU_CLZ);
    check_res("clz_msb", 32'd0, 1'b0);
    run_ab(32'h8000_0000, 32'h0, ALU_ABS);
    check_res("abs_min", 32'h8000_0000, 1'b0);
    run_ab(32'hFFFF_FFFF, 32'd1, ALU_ADD);
    check_res("add_wrap", 32'h0, 1'b1);

    // Source mapping: source s carries s*0x1001.
    for (int s = 1; s <= N; s++) set_src(s, 32'(s * 32'h1001));
    set_cfg(4'd1, 4'(N), ALU_ADD);
    step();
    check_res("src_top_bottom", 32'h0000_9009, 1'b0);
    set_cfg(4'd0, 4'(N), ALU_ADD);
    step();
    check_res("src_sel0", 32'h0000_8008, 1'b0);
    set_cfg(4'd9, 4'd2, ALU_OR);
    step();
    check_res("src_sel_over", 32'h0000_2002, 1'b0);
    set_cfg(4'd3, 4'd0, ALU_OR);
    step();
    check_res("src3_b0", 32'h0000_3003, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/versat_alu.md
Name: versat_alu

Overview:
- Registered 32-bit ALU functional unit for the Versat datapath.
- Picks two operands from the shared data bus using configuration selects and applies one of 16 functions; result and carry/compare flag are registered.
- The controller can overwrite the output register directly through the rw port.
- The leading-zero counter is a separate combinational sub-module.

Parameters:
- DATA_W, 32, operand/result width.
- N, 8, number of data-bus sources.
- N_W, 4, width of a source select; must satisfy 2^N_W > N.
- ALU_FNS_W, 4, function-code width.
- ALU_CONF_BITS, 2*N_W+ALU_FNS_W, configuration word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rw_req  in  1  controller access request.
- rw_rnw  in  1  1 = read, 0 = write.
- rw_data_to_wr  in  DATA_W  controller write data.
- data_bus  in  N*DATA_W  shared source bus; source s (1..N) occupies bits [N*DATA_W-DATA_W*(s-1)-1 -: DATA_W], so source 1 is the top slice.
- alu_result  out  DATA_W  registered result.
- c_out  out  1  registered carry/compare flag.
- configdata  in  ALU_CONF_BITS  [ALU_CONF_BITS-1 -: N_W] = selA; next N_W bits = selB; [ALU_FNS_W-1:0] = fns.

Behaviour:
- Operand select: A = slice selA, B = slice selB. A select of 0 or greater than N gives operand 0.
- Reset (rst low, asynchronous): alu_result = 0, c_out = 0.
- Each rising edge, priority 1: if rw_req=1 and rw_rnw=0, alu_result <= rw_data_to_wr and c_out <= 0.
- Otherwise alu_result <= f(A,B) per fns. Latency is one cycle from operand/config change to output.
- Function codes (fns):
  - 0 OR: A|B
  - 1 AND: A&B
  - 2 ANDN: A&~B
  - 3 XOR: A^B
  - 4 SEXT8: sign-extend A[7:0]
  - 5 SEXT16: sign-extend A[15:0]
  - 6 SHIFTR_ARTH: A>>1, bit31 = A[31]
  - 7 SHIFTR_LOG: A>>1, bit31 = 0
  - 8 CMP_UNS: B+~A+1
  - 9 CMP_SIG: B+~A+1
  - 10 ADD: A+B
  - 11 SUB: B-A
  - 12 CLZ: leading zeros of A, range 0..32, zero-extended
  - 13 MAX: signed max(A,B)
  - 14 MIN: signed min(A,B)
  - 15 ABS: A[31] ? ~A+1 : A
- All arithmetic is modulo 2^32. ABS(0x80000000) = 0x80000000. CLZ(0) = 32.
- MAX/MIN: when signs differ, select by sign; otherwise by unsigned compare. On tie, return B.
- c_out:
  - ADD: carry out of A+B.
  - SUB and CMP_UNS: carry of B+~A+1, i.e. 1 when B >= A unsigned.
  - CMP_SIG: 1 when B >= A signed.
  - All other functions: 0.
- rw read (rw_req=1, rw_rnw=1) has no side effect; the normal function update continues.
- Reset mid-operation clears the outputs immediately; the first post-reset edge computes normally.

Decomposition:
- Shared package/header: DATA_W, N, N_W, ALU_FNS_W, ALU_CONF_BITS, and the 16 function-code constants above.
- Sub-module alu_clz: combinational, DATA_W input, 6-bit count output; upper result bits are tied to 0.

Test Plan:
- Reset low mid-cycle -> alu_result = 0 and c_out = 0 immediately. Release, then rw_req=1, rw_rnw=0, data = 20 -> alu_result = 20 after next edge.
- A=25, B=26, rw_rnw=1, step fns 0..15 one per cycle -> results 27, 24, 1, 3, 25, 25, 12, 12, 1, 1, 51, 1, 27, 26, 25, 25, each one cycle after its code.
- A=0xFFFFFF80 -> SEXT8 = 0xFFFFFF80, SEXT16 = 0xFFFFFF80, SHIFTR_ARTH = 0xFFFFFFC0, SHIFTR_LOG = 0x7FFFFFC0, ABS = 0x80.
- A=0xFFFFFFFF (-1), B=3 -> MAX = 3, MIN = 0xFFFFFFFF, CMP_SIG c_out = 1, CMP_UNS c_out = 0.
- CLZ: A=0 -> 32, A=1 -> 31, A=0x80000000 -> 0. ABS(0x80000000) -> 0x80000000. ADD 0xFFFFFFFF+1 -> 0 with c_out = 1.
- Source mapping: selA=1, selB=N with distinct bus values, ADD -> sum of the top and bottom slices. selA=0 -> A treated as 0.
